// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, bubble instruction, reset PC and fetch FSM states.
package core_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_KILL
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset > flush > stall > misalign marker > load > bubble.
// FETCH_ALIGN_CHECK_EN adds the misalign marker input and MisalignD-style output.
module if_id_reg #(
    parameter int unsigned XLEN      = core_pkg::XLEN,
    parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            stall_i,
    input  logic            load_i,
`ifdef FETCH_ALIGN_CHECK_EN
    input  logic            misalign_i,
    output logic            misalign_o,
`endif
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pcplus4_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pcplus4_o,
    output logic            valid_o
);
    import core_pkg::*;

    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pcplus4_q;
    logic            valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
    logic            mis_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q   <= NOP_INSTR;
            pc_q      <= '0;
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            mis_q     <= 1'b0;
`endif
        end else if (flush_i) begin
            // Flush keeps the PC fields so a later exception sees the last real PC.
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            mis_q   <= 1'b0;
`endif
        end else if (stall_i) begin
            instr_q <= instr_q;
`ifdef FETCH_ALIGN_CHECK_EN
        end else if (misalign_i) begin
            instr_q   <= NOP_INSTR;
            pc_q      <= pc_i;
            pcplus4_q <= pcplus4_i;
            valid_q   <= 1'b1;
            mis_q     <= 1'b1;
`endif
        end else if (load_i) begin
            instr_q   <= instr_i;
            pc_q      <= pc_i;
            pcplus4_q <= pcplus4_i;
            valid_q   <= 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
            mis_q     <= 1'b0;
`endif
        end else begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            mis_q   <= 1'b0;
`endif
        end
    end

    assign instr_o   = instr_q;
    assign pc_o      = pc_q;
    assign pcplus4_o = pcplus4_q;
    assign valid_o   = valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign_o = mis_q;
`endif

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, req/ack imem FSM with redirect-kill, feeding the IF/ID register.
// FETCH_ALIGN_CHECK_EN: misaligned redirects park fetch in IDLE and flag MisalignD.
module fetch_stage #(
    parameter int unsigned     XLEN      = core_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = core_pkg::RESET_PC,
    parameter logic [31:0]     NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            FetchWaitF,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic            MisalignD,
`endif
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);
    import core_pkg::*;

    localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic [XLEN-1:0] tgt_in;
    logic [XLEN-1:0] load_pc;
    logic            load_en;
    logic            req_q;
    logic            usable;

`ifdef FETCH_ALIGN_CHECK_EN
    logic hold_q, hold_d;
    logic mis_q, mis_d;
    assign tgt_in = PCTargetE;
`else
    logic unused_tgt_lsb;
    assign unused_tgt_lsb = ^PCTargetE[1:0];
    assign tgt_in = {PCTargetE[XLEN-1:2], 2'b00};
`endif

    assign usable = (state_q == FETCH_REQ) && imem_ack;

    always_comb begin
        state_d = state_q;
        pcf_d   = pcf_q;
        tgt_d   = tgt_q;
        load_en = 1'b0;
        load_pc = tgt_q;
        unique case (state_q)
            FETCH_IDLE: begin
`ifdef FETCH_ALIGN_CHECK_EN
                if (!hold_q) begin
                    state_d = FETCH_REQ;
                end else if (PCSrcE) begin
                    load_en = 1'b1;
                    load_pc = tgt_in;
                end
`else
                state_d = FETCH_REQ;
`endif
            end
            FETCH_REQ: begin
                if (imem_ack) begin
                    if (PCSrcE) begin
                        load_en = 1'b1;
                        load_pc = tgt_in;
                    end else if (!StallF) begin
                        pcf_d = pcf_q + PC_INC;
                    end
                end else if (PCSrcE) begin
                    // Address must stay put until the in-flight response returns.
                    tgt_d   = tgt_in;
                    state_d = FETCH_KILL;
                end
            end
            FETCH_KILL: begin
                if (PCSrcE) tgt_d = tgt_in;
                if (imem_ack) begin
                    load_en = 1'b1;
                    load_pc = PCSrcE ? tgt_in : tgt_q;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase
        if (load_en) begin
            pcf_d   = load_pc;
            state_d = FETCH_REQ;
        end
`ifdef FETCH_ALIGN_CHECK_EN
        hold_d = hold_q;
        mis_d  = mis_q && (FlushD || StallD);
        if (load_en) begin
            hold_d = |load_pc[1:0];
            mis_d  = |load_pc[1:0];
            if (|load_pc[1:0]) state_d = FETCH_IDLE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH_IDLE;
            pcf_q   <= RESET_PC;
            tgt_q   <= '0;
            req_q   <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            hold_q  <= 1'b0;
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pcf_q   <= pcf_d;
            tgt_q   <= tgt_d;
            req_q   <= (state_d != FETCH_IDLE);
`ifdef FETCH_ALIGN_CHECK_EN
            hold_q  <= hold_d;
            mis_q   <= mis_d;
`endif
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = pcf_q;
    assign FetchWaitF = req_q && !usable;

    if_id_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (FlushD),
        .stall_i    (StallD),
        .load_i     (usable),
`ifdef FETCH_ALIGN_CHECK_EN
        .misalign_i (mis_q),
        .misalign_o (MisalignD),
`endif
        .instr_i    (imem_rdata),
        .pc_i       (pcf_q),
        .pcplus4_i  (pcf_q + PC_INC),
        .instr_o    (InstrD),
        .pc_o       (PCD),
        .pcplus4_o  (PCPlus4D),
        .valid_o    (ValidD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: per-cycle vector table for corner cases, then a scoreboarded random stream.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst, StallF, StallD, FlushD, PCSrcE, imem_ack;
    logic        imem_req, FetchWaitF, ValidD;
    logic [31:0] PCTargetE, imem_addr, imem_rdata, InstrD, PCD, PCPlus4D;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        MisalignD;
`endif

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    assign imem_rdata = memf(imem_addr);

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .FetchWaitF (FetchWaitF),
`ifdef FETCH_ALIGN_CHECK_EN
        .MisalignD  (MisalignD),
`endif
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst, sf, sd, fd, pcs;
        logic [31:0] tgt;
        logic        ack;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_wait, e_vld;
        logic [31:0] e_instr, e_pcd, e_pcp4;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] sb[$];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic vec_t mk(input logic r, sf, sd, fd, pcs, input logic [31:0] tgt,
                                input logic ack, input logic e_req, input logic [31:0] e_addr,
                                input logic e_wait, e_vld, input logic [31:0] e_instr, e_pcd, e_pcp4);
        vec_t v;
        v.rst = r; v.sf = sf; v.sd = sd; v.fd = fd; v.pcs = pcs; v.tgt = tgt; v.ack = ack;
        v.e_req = e_req; v.e_addr = e_addr; v.e_wait = e_wait; v.e_vld = e_vld;
        v.e_instr = e_instr; v.e_pcd = e_pcd; v.e_pcp4 = e_pcp4;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst = v.rst; StallF = v.sf; StallD = v.sd; FlushD = v.fd;
        PCSrcE = v.pcs; PCTargetE = v.tgt; imem_ack = v.ack;
        #1;
        n_vec++;
        chk("imem_req", idx, 32'(imem_req), 32'(v.e_req));
        chk("imem_addr", idx, imem_addr, v.e_addr);
        chk("FetchWaitF", idx, 32'(FetchWaitF), 32'(v.e_wait));
        @(posedge clk);
        #1;
        chk("ValidD", idx, 32'(ValidD), 32'(v.e_vld));
        chk("InstrD", idx, InstrD, v.e_instr);
        chk("PCD", idx, PCD, v.e_pcd);
        chk("PCPlus4D", idx, PCPlus4D, v.e_pcp4);
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] p;
        logic        a, s, pushed;

        rst = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        PCSrcE = 1'b0; PCTargetE = '0; imem_ack = 1'b0;
        @(posedge clk);

        //      rst sf sd fd pcs tgt            ack  req addr           wt vld instr                  pcd            pcp4
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,          1, 0, 32'h0,          0, 0, NOP,                   32'h0,         32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,          1, 0, 32'h0,          0, 0, NOP,                   32'h0,         32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,          1, 1, 32'h0,          0, 1, memf(32'h0),           32'h0,         32'h4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,          1, 1, 32'h4,          0, 1, memf(32'h4),           32'h4,         32'h8));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,          1, 1, 32'h8,          0, 1, memf(32'h8),           32'h8,         32'hC));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,          1, 1, 32'hC,          0, 1, memf(32'hC),           32'hC,         32'h10));
        tbl.push_back(mk(0, 1, 1, 0, 0, 32'h0,          1, 1, 32'h10,         0, 1, memf(32'hC),           32'hC,         32'h10));
        tbl.push_back(mk(0, 1, 1, 0, 0, 32'h0,          1, 1, 32'h10,         0, 1, memf(32'hC),           32'hC,         32'h10));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,          1, 1, 32'h10,         0, 1, memf(32'h10),          32'h10,        32'h14));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,          1, 1, 32'h14,         0, 1, memf(32'h14),          32'h14,        32'h18));
        tbl.push_back(mk(0, 0, 0, 1, 1, 32'h100,        1, 1, 32'h18,         0, 0, NOP,                   32'h14,        32'h18));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,          1, 1, 32'h100,        0, 1, memf(32'h100),         32'h100,       32'h104));
        tbl.push_back(mk(0, 0, 1, 1, 0, 32'h0,          1, 1, 32'h104,        0, 0, NOP,                   32'h100,       32'h104));
        tbl.push_back(mk(0, 0, 0, 1, 1, 32'h20,         1, 1, 32'h108,        0, 0, NOP,                   32'h100,       32'h104));
        tbl.push_back(mk(0, 0, 0, 1, 1, 32'h80,         0, 1, 32'h20,         1, 0, NOP,                   32'h100,       32'h104));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,          0, 1, 32'h20,         1, 0, NOP,                   32'h100,       32'h104));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,          0, 1, 32'h20,         1, 0, NOP,                   32'h100,       32'h104));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,          1, 1, 32'h20,         1, 0, NOP,                   32'h100,       32'h104));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,          1, 1, 32'h80,         0, 1, memf(32'h80),          32'h80,        32'h84));
        tbl.push_back(mk(0, 0, 0, 1, 1, 32'h203,        1, 1, 32'h84,         0, 0, NOP,                   32'h80,        32'h84));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,          1, 1, 32'h200,        0, 1, memf(32'h200),         32'h200,       32'h204));
        tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0,          1, 1, 32'h204,        0, 1, memf(32'h204),         32'h204,       32'h208));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,          1, 1, 32'h204,        0, 1, memf(32'h204),         32'h204,       32'h208));
        tbl.push_back(mk(0, 0, 0, 1, 1, 32'h300,        0, 1, 32'h208,        1, 0, NOP,                   32'h204,       32'h208));
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'h0,          0, 1, 32'h208,        1, 0, NOP,                   32'h0,         32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,          1, 0, 32'h0,          0, 0, NOP,                   32'h0,         32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,          1, 1, 32'h0,          0, 1, memf(32'h0),           32'h0,         32'h4));
        tbl.push_back(mk(0, 0, 0, 1, 1, 32'hFFFF_FFFC,  1, 1, 32'h4,          0, 0, NOP,                   32'h0,         32'h4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,          1, 1, 32'hFFFF_FFFC,  0, 1, memf(32'hFFFF_FFFC),   32'hFFFF_FFFC, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,          1, 1, 32'h0,          0, 1, memf(32'h0),           32'h0,         32'h4));
        tbl.push_back(mk(0, 0, 0, 1, 1, 32'h40,         0, 1, 32'h4,          1, 0, NOP,                   32'h0,         32'h4));
        tbl.push_back(mk(0, 0, 0, 1, 1, 32'h60,         0, 1, 32'h4,          1, 0, NOP,                   32'h0,         32'h4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,          1, 1, 32'h4,          1, 0, NOP,                   32'h0,         32'h4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,          1, 1, 32'h60,         0, 1, memf(32'h60),          32'h60,        32'h64));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,          0, 1, 32'h64,         1, 0, NOP,                   32'h60,        32'h64));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,          1, 1, 32'h64,         0, 1, memf(32'h64),          32'h64,        32'h68));
        tbl.push_back(mk(0, 1, 0, 1, 1, 32'h500,        1, 1, 32'h68,         0, 0, NOP,                   32'h64,        32'h68));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0,          1, 1, 32'h500,        0, 1, memf(32'h500),         32'h500,       32'h504));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        // Random stream: paired stalls and ack gaps, expected fetches queued as they are driven.
        @(negedge clk);
        rst = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; imem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; imem_ack = 1'b1;
        #1;
        n_vec++;
        chk("stream idle req", 0, 32'(imem_req), 32'h0);
        @(posedge clk);
        exp_pc = 32'h0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            a = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 4) == 0);
            imem_ack = a; StallF = s; StallD = s;
            #1;
            n_vec++;
            chk("stream addr", i, imem_addr, exp_pc);
            chk("stream wait", i, 32'(FetchWaitF), 32'(!a));
            pushed = a && !s;
            if (pushed) begin
                sb.push_back(exp_pc);
                exp_pc = exp_pc + 32'h4;
            end
            @(posedge clk);
            #1;
            if (pushed) begin
                p = sb.pop_front();
                chk("stream ValidD", i, 32'(ValidD), 32'h1);
                chk("stream InstrD", i, InstrD, memf(p));
                chk("stream PCD", i, PCD, p);
                chk("stream PCPlus4D", i, PCPlus4D, p + 32'h4);
            end else if (!s) begin
                chk("stream bubble", i, 32'(ValidD), 32'h0);
            end
        end
        n_vec++;
        chk("stream drained", 0, 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
